// File: rtl/cla_pkg.sv
// Shared widths, the group propagate/generate pair and the group P/G reduction
// used by the 16-bit two-stage lookahead adder.
package cla_pkg;

    localparam int DATA_W = 16;
    localparam int GRP_W  = 4;
    localparam int N_GRP  = 4;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Block propagate/generate of a 4-bit slice; bit 0 is the least significant.
    function automatic pg_t group_pg(input logic [GRP_W-1:0] p, input logic [GRP_W-1:0] g);
        pg_t r;
        r.p = &p;
        r.g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// 4-wide carry-lookahead unit: internal carries 1..3, carry-out and block P/G.
// Purely combinational; no state, no handshake.
module cla_lookahead4
    import cla_pkg::*;
(
    input  pg_t [GRP_W-1:0] pg,
    input  logic            c_in,
    output logic [GRP_W-2:0] c,
    output logic            c_out,
    output pg_t             blk
);

    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] g;

    always_comb begin
        for (int k = 0; k < GRP_W; k++) begin
            p[k] = pg[k].p;
            g[k] = pg[k].g;
        end
    end

    always_comb begin
        c[0]  = g[0] | (p[0] & c_in);
        c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
        blk   = group_pg(p, g);
        c_out = blk.g | (blk.p & c_in);
    end

endmodule

// File: rtl/cla_pipe_adder16.sv
// Two-stage pipelined 16-bit lookahead adder with tag sideband; CLA_OVF_EN adds a signed overflow output.
// Latency 2 cycles from accept to out_valid, one op per cycle when out_ready stays high.
// Backpressure: stall S2 while out_valid & !out_ready; in_ready = !s1_valid | s2 advance.
module cla_pipe_adder16
    import cla_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum,
    output logic              c_out,
    output logic [TAG_W-1:0]  out_tag
`ifdef CLA_OVF_EN
    ,
    output logic              ovf
`endif
);

    logic                    s1_valid;
    logic [DATA_W-1:0]       s1_p;
    logic [DATA_W-1:0]       s1_g;
    pg_t  [N_GRP-1:0]        s1_grp;
    logic                    s1_cin;
    logic [TAG_W-1:0]        s1_tag;

    logic                    s2_valid;
    logic [DATA_W-1:0]       s2_sum;
    logic                    s2_cout;
    logic [TAG_W-1:0]        s2_tag;

    logic                    s1_advance;
    logic                    s2_advance;

    logic [DATA_W-1:0]       in_p;
    logic [DATA_W-1:0]       in_g;
    pg_t  [N_GRP-1:0]        in_grp;

    logic [N_GRP-2:0]        grp_c;
    logic                    c16;
    pg_t                     top_blk;
    logic [N_GRP-1:0]        grp_cin;
    logic [N_GRP-1:0]        grp_cout;
    pg_t  [N_GRP-1:0]        grp_blk;
    logic [DATA_W-1:0]       carry;
    logic [DATA_W-1:0]       sum_nxt;

    assign s2_advance = !s2_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    assign in_p = a ^ b;
    assign in_g = a & b;

    always_comb begin
        for (int i = 0; i < N_GRP; i++) begin
            in_grp[i] = group_pg(in_p[i*GRP_W +: GRP_W], in_g[i*GRP_W +: GRP_W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_grp   <= '0;
            s1_cin   <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p   <= in_p;
                s1_g   <= in_g;
                s1_grp <= in_grp;
                s1_cin <= c_in;
                s1_tag <= in_tag;
            end
        end
    end

    // Second lookahead level: group carries c4, c8, c12 and c16 from group P/G.
    cla_lookahead4 u_top (
        .pg    (s1_grp),
        .c_in  (s1_cin),
        .c     (grp_c),
        .c_out (c16),
        .blk   (top_blk)
    );

    assign grp_cin = {grp_c, s1_cin};

    for (genvar j = 0; j < N_GRP; j++) begin : g_grp
        pg_t [GRP_W-1:0] bit_pg;

        for (genvar k = 0; k < GRP_W; k++) begin : g_bit
            assign bit_pg[k] = pg_t'{p: s1_p[j*GRP_W+k], g: s1_g[j*GRP_W+k]};
        end

        assign carry[j*GRP_W] = grp_cin[j];

        cla_lookahead4 u_grp (
            .pg    (bit_pg),
            .c_in  (grp_cin[j]),
            .c     (carry[j*GRP_W+1 +: GRP_W-1]),
            .c_out (grp_cout[j]),
            .blk   (grp_blk[j])
        );
    end

    // Slice carry-outs and block P/G duplicate the top-level carries and are not needed.
    logic unused_lookahead;
    assign unused_lookahead = ^{grp_cout, grp_blk, top_blk};

    assign sum_nxt = s1_p ^ carry;

`ifdef CLA_OVF_EN
    logic s2_ovf;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_cout  <= 1'b0;
            s2_tag   <= '0;
`ifdef CLA_OVF_EN
            s2_ovf   <= 1'b0;
`endif
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= sum_nxt;
                s2_cout <= c16;
                s2_tag  <= s1_tag;
`ifdef CLA_OVF_EN
                s2_ovf  <= carry[DATA_W-1] ^ c16;
`endif
            end
        end
    end

    assign out_valid = s2_valid;
    assign sum       = s2_sum;
    assign c_out     = s2_cout;
    assign out_tag   = s2_tag;
`ifdef CLA_OVF_EN
    assign ovf       = s2_ovf;
`endif

endmodule

// File: doc/cla_pipe_adder16.md
CLA_PIPE_ADDER16 -- requirements
Module: cla_pipe_adder16

Interface
REQ-001 SHALL have parameter: TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-002 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operand presented.
REQ-005 SHALL have port: in_ready  output  1  adder can accept operand this cycle.
REQ-006 SHALL have port: a  input  16  operand A.
REQ-007 SHALL have port: b  input  16  operand B.
REQ-008 SHALL have port: c_in  input  1  carry-in.
REQ-009 SHALL have port: in_tag  input  TAG_W  sideband tag, returned unchanged.
REQ-010 SHALL have port: out_valid  output  1  result held.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: sum  output  16  a+b+c_in, low 16 bits.
REQ-013 SHALL have port: c_out  output  1  carry out of bit 15.
REQ-014 SHALL have port: out_tag  output  TAG_W  tag of the result.
REQ-015 SHALL have port (only with CLA_OVF_EN): ovf  output  1  signed two's-complement overflow.

Function
REQ-016 SHALL use two register stages: S1 holds per-bit p=a^b, g=a&b, 4-bit group P/G, c_in, tag; S2 holds sum, c_out, tag (and ovf).
REQ-017 SHALL form group carries in S1->S2 by two-level lookahead: group carries c4,c8,c12,c16 from group P/G and c_in; in-group carries from bit p/g and group carry.
REQ-018 SHALL have latency exactly 2 cycles from accepted input (in_valid&in_ready) to out_valid with no backpressure.
REQ-019 SHALL sustain one operation per cycle when out_ready is held high.
REQ-020 SHALL transfer input only when in_valid&in_ready, output only when out_valid&out_ready.
REQ-021 SHALL advance S2 when S2 empty or out_ready; SHALL advance S1 when S1 empty or S2 advances.
REQ-022 SHALL drive in_ready = !s1_valid | s2_advance (combinational, no dependence on in_valid).
REQ-023 SHALL hold sum, c_out, out_tag, ovf stable while out_valid&!out_ready.
REQ-024 SHALL preserve order; no operation dropped or duplicated under any out_ready pattern.
REQ-025 SHALL, on simultaneous output drain and input accept with both stages full, move S1->S2 and load S1 in the same cycle.
REQ-026 SHALL wrap modulo 2^16: overflow past bit 15 appears only on c_out.

Reset
REQ-027 SHALL, on rst high, immediately clear s1_valid and s2_valid; out_valid=0, sum=0, c_out=0, out_tag=0, ovf=0.
REQ-028 SHALL discard in-flight operations on reset mid-operation; in_ready=1 first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with CLA_OVF_EN defined, register ovf = c15^c16 in S2 alongside sum.
REQ-030 SHALL, without CLA_OVF_EN, omit ovf port and its logic; all other behaviour identical.

Structure
REQ-031 SHALL place constants DATA_W=16, GRP_W=4, N_GRP=4 and the group P/G pair typedef in shared package cla_pkg.
REQ-032 SHALL instantiate sub-module cla_lookahead4 (4 P/G + carry-in -> 3 internal carries, carry-out, block P/G) five times: one top-level, four in-group.

Verification
REQ-033 SHALL test a=0xFFFF,b=0x0001,c_in=0 -> 2 cycles later sum=0x0000,c_out=1.
REQ-034 SHALL test a=0x1234,b=0x4321,c_in=1,tag=0x5 -> sum=0x5556,c_out=0,out_tag=0x5.
REQ-035 SHALL test 4 back-to-back ops with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
REQ-036 SHALL test out_ready=0 for 4 cycles while in_valid=1 -> in_ready falls after 2 accepts; results held stable; on out_ready=1 all drain in order.
REQ-037 SHALL test (CLA_OVF_EN) a=0x7FFF,b=0x0001 -> sum=0x8000,ovf=1,c_out=0; a=0x8000,b=0x8000 -> sum=0,ovf=1,c_out=1.
REQ-038 SHALL test rst pulse with both stages full -> out_valid=0 same cycle, no stale result after release.
